led_shift_driver: RTL

Parametrised serial driver for chains of shift-register LED drivers (74HC595-class): accepts a parallel word via valid/ready handshake and shifts it out on a generated serial clock. It then pulses a latch so all devices update their outputs together. Generalises the fixed 16-bit LED serialiser to any device width, chain length and bit order. Adds a divided serial clock, a transfer handshake and an optional auto-refresh mode. Sits between the display/pattern logic and the board pins.

---
 rtl/led_shift_driver_pkg.sv | 10 +
 rtl/led_shift_driver_if.sv | 11 +
 rtl/led_shift_driver_clk_div.sv | 19 +
 rtl/led_shift_driver.sv | 91 +++++++++
 4 files changed

// File: rtl/led_shift_driver_pkg.sv
// led_shift_driver_pkg: shared state encoding and sizing helpers for the LED chain driver
package led_shift_driver_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  function automatic int calc_total(input int data_w, input int n_dev);
    return data_w * n_dev;
  endfunction
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/led_shift_driver_if.sv
// led_shift_driver_if: frame handshake and board-side serial pins of the LED chain driver
interface led_shift_driver_if #(parameter int TOTAL = 16) ();
  logic [TOTAL-1:0] data_in;
  logic             load;
  logic             ready;
  logic             sclk;
  logic             sdata;
  logic             latch;
  modport master (output data_in, load, input ready, sclk, sdata, latch);
  modport slave  (input data_in, load, output ready, sclk, sdata, latch);
endinterface

// File: rtl/led_shift_driver_clk_div.sv
// led_clk_div: terminal-count pulse every CLK_DIV cycles, held at zero while restart is high
module led_clk_div
  import led_shift_driver_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tc
);
  localparam int W = cnt_w(CLK_DIV);
  logic [W-1:0] r_cnt;
  assign o_tc = !i_restart && (r_cnt == W'(CLK_DIV - 1));
  // count up and wrap on terminal count so each state lasts exactly CLK_DIV cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (i_restart || o_tc) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises a parallel frame into a 74HC595-style chain and pulses latch
module led_shift_driver
  import led_shift_driver_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_DEV     = 2,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1,
  parameter int REFRESH   = 0
) (
  input  logic                clk,
  input  logic                rst,
  led_shift_driver_if.slave   bus
);
  localparam int TOTAL = calc_total(DATA_W, N_DEV);
  localparam int BW    = cnt_w(TOTAL);
  state_t           r_state;
  logic [TOTAL-1:0] r_frame, r_shift;
  logic [BW-1:0]    r_bits;
  logic             r_valid, r_ready, r_sclk, r_sdata, r_latch;
  logic             w_tc, w_restart, w_accept, w_refresh, w_last;
  logic [TOTAL-1:0] w_src, w_next;
  assign w_restart = (r_state == IDLE);
  assign w_accept  = bus.load && r_ready;
  assign w_refresh = (REFRESH != 0) && (r_state == IDLE) && !bus.load && r_valid;
  assign w_src     = w_accept ? bus.data_in : r_frame;
  assign w_next    = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_last    = (r_bits == BW'(TOTAL - 1));
  led_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tc      (w_tc)
  );
  // frame FSM; outputs are registered together with the state they belong to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_shift <= '0;
      r_bits  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept || w_refresh) begin
            r_state <= SHIFT_LO;
            r_shift <= w_src;
            r_bits  <= '0;
            r_ready <= 1'b0;
            r_sdata <= (MSB_FIRST != 0) ? w_src[TOTAL-1] : w_src[0];
            if (w_accept) begin
              r_frame <= bus.data_in;
              r_valid <= 1'b1;
            end
          end else r_ready <= 1'b1;
        end
        SHIFT_LO: if (w_tc) begin
          r_state <= SHIFT_HI;
          r_sclk  <= 1'b1;
        end
        SHIFT_HI: if (w_tc) begin
          r_sclk  <= 1'b0;
          r_shift <= w_next;
          if (w_last) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_bits  <= '0;
          end else begin
            r_state <= SHIFT_LO;
            r_bits  <= r_bits + 1'b1;
            r_sdata <= (MSB_FIRST != 0) ? w_next[TOTAL-1] : w_next[0];
          end
        end
        LATCH: if (w_tc) begin
          r_state <= IDLE;
          r_latch <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.ready = r_ready;
  assign bus.sclk  = r_sclk;
  assign bus.sdata = r_sdata;
  assign bus.latch = r_latch;
endmodule
